// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial receive blocks.
package serial_rx_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DATA     = 3'd1,
      PARITY   = 3'd2,
      STOP     = 3'd3,
      DONE     = 3'd4,
      ERR_WAIT = 3'd5
   } rx_state_t;

   localparam logic IDLE_LEVEL = 1'b1;

   // Bit-counter width; a 1-bit floor keeps tiny frames legal.
   function automatic int cnt_width(input int data_w);
      return (data_w <= 2) ? 1 : $clog2(data_w);
   endfunction

endpackage

// File: rtl/serial_parity_acc.sv
// Running XOR accumulator: clear takes priority over en.
module serial_parity_acc (
   input  logic clk,
   input  logic areset,
   input  logic clear,
   input  logic en,
   input  logic bit_in,
   output logic par
);

   logic par_reg;

   always_ff @(posedge clk or posedge areset) begin
      if (areset)
         par_reg <= 1'b0;
      else if (clear)
         par_reg <= 1'b0;
      else if (en)
         par_reg <= par_reg ^ bit_in;
   end

   assign par = par_reg;

endmodule

// File: rtl/serial_frame_rx.sv
// Start/data/odd-parity/stop frame receiver with done, parity and framing flags.
module serial_frame_rx
   import serial_rx_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int PARITY_EN = 1
) (
   input  logic              clk,
   input  logic              areset,
   input  logic              in,
   output logic [DATA_W-1:0] out_byte,
   output logic              done,
   output logic              parity_err,
   output logic              frame_err
);

   localparam int             CW   = cnt_width(DATA_W);
   localparam logic [CW-1:0]  LAST = CW'(DATA_W - 1);

   rx_state_t         state_reg;
   logic [CW-1:0]     cnt_reg;
   logic [DATA_W-1:0] shreg_reg;
   logic [DATA_W-1:0] out_byte_reg;
   logic              parity_err_reg;
   logic              frame_err_reg;

   logic start_seen;
   logic par_clear;
   logic par_en;
   logic par;

   // A start bit is accepted from IDLE or straight out of DONE (back-to-back).
   assign start_seen = ((state_reg == IDLE) || (state_reg == DONE)) && (in != IDLE_LEVEL);
   assign par_clear  = start_seen;
   assign par_en     = (state_reg == DATA) || (state_reg == PARITY);

   serial_parity_acc u_parity (
      .clk    (clk),
      .areset (areset),
      .clear  (par_clear),
      .en     (par_en),
      .bit_in (in),
      .par    (par)
   );

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         shreg_reg      <= '0;
         out_byte_reg   <= '0;
         parity_err_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
      end else begin
         parity_err_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         case (state_reg)
            IDLE, DONE: begin
               cnt_reg <= '0;
               if (start_seen)
                  state_reg <= DATA;
               else
                  state_reg <= IDLE;
            end
            DATA: begin
               shreg_reg <= {in, shreg_reg[DATA_W-1:1]};
               if (cnt_reg == LAST) begin
                  cnt_reg   <= '0;
                  state_reg <= (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            PARITY: begin
               state_reg <= STOP;
            end
            STOP: begin
               if (in == IDLE_LEVEL) begin
                  state_reg      <= DONE;
                  out_byte_reg   <= shreg_reg;
                  parity_err_reg <= (PARITY_EN != 0) && (par != 1'b1);
               end else begin
                  state_reg     <= ERR_WAIT;
                  frame_err_reg <= 1'b1;
               end
            end
            ERR_WAIT: begin
               if (in == IDLE_LEVEL)
                  state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign out_byte   = out_byte_reg;
   assign done       = (state_reg == DONE);
   assign parity_err = parity_err_reg;
   assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Drives one serial line into a parity and a no-parity receiver and checks both
// against a frame-level parse of the same bit stream.
module tb_serial_frame_rx;

   localparam int W    = 8;
   localparam int MAXN = 2048;

   logic       clk = 1'b0;
   logic       areset;
   logic       in;
   logic [W-1:0] ob_p, ob_n;
   logic       done_p, done_n, perr_p, perr_n, ferr_p, ferr_n;

   int checks = 0;
   int errors = 0;

   bit           stream_q[$];
   logic         exp_done[2][MAXN];
   logic         exp_perr[2][MAXN];
   logic         exp_ferr[2][MAXN];
   logic [W-1:0] exp_byte[2][MAXN];
   logic [W-1:0] last_byte[2];

   always #5 clk = ~clk;

   serial_frame_rx #(.DATA_W(W), .PARITY_EN(1)) dut_p (
      .clk(clk), .areset(areset), .in(in),
      .out_byte(ob_p), .done(done_p), .parity_err(perr_p), .frame_err(ferr_p)
   );

   serial_frame_rx #(.DATA_W(W), .PARITY_EN(0)) dut_n (
      .clk(clk), .areset(areset), .in(in),
      .out_byte(ob_n), .done(done_n), .parity_err(perr_n), .frame_err(ferr_n)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_frame(input logic [W-1:0] w, input bit with_par, input bit bad_par,
                             input bit stop, input int idle);
      stream_q.push_back(1'b0);
      for (int b = 0; b < W; b++) stream_q.push_back(w[b]);
      if (with_par) stream_q.push_back((~^w) ^ bad_par);
      stream_q.push_back(stop);
      repeat (idle) stream_q.push_back(1'b1);
   endtask

   // Frame-level parse: find each start bit, slice out the fields, judge the stop bit.
   task automatic build_expect(input int pe);
      int n, pos, s, ones;
      logic [W-1:0] word, held;
      n = stream_q.size();
      for (int i = 0; i < n; i++) begin
         exp_done[pe][i] = 1'b0;
         exp_perr[pe][i] = 1'b0;
         exp_ferr[pe][i] = 1'b0;
         exp_byte[pe][i] = '0;
      end
      pos = 0;
      while (pos < n) begin
         if (stream_q[pos] == 1'b1) begin
            pos++;
         end else begin
            s = pos + W + 1 + pe;
            if (s >= n) break;
            word = '0;
            ones = 0;
            for (int b = 0; b < W; b++) begin
               word[b] = stream_q[pos + 1 + b];
               ones += int'(stream_q[pos + 1 + b]);
            end
            if (pe != 0) ones += int'(stream_q[pos + W + 1]);
            if (stream_q[s] == 1'b1) begin
               exp_done[pe][s] = 1'b1;
               exp_perr[pe][s] = (pe != 0) && (ones % 2 == 0);
               exp_byte[pe][s] = word;
               pos = s + 1;
            end else begin
               exp_ferr[pe][s] = 1'b1;
               pos = s + 1;
               while (pos < n && stream_q[pos] == 1'b0) pos++;
               pos++;
            end
         end
      end
      held = last_byte[pe];
      for (int i = 0; i < n; i++) begin
         if (exp_done[pe][i]) held = exp_byte[pe][i];
         exp_byte[pe][i] = held;
      end
      last_byte[pe] = held;
   endtask

   // Called at a negedge; bit i is sampled at the next posedge and its effect
   // is checked on the following negedge.
   task automatic run_stream(input string name);
      int n;
      repeat (W + 4) stream_q.push_back(1'b1);
      n = stream_q.size();
      if (n > MAXN) begin
         $display("FAIL %s stream_len got %0d limit %0d", name, n, MAXN);
         $fatal(1);
      end
      build_expect(0);
      build_expect(1);
      for (int i = 0; i < n; i++) begin
         in = stream_q[i];
         @(posedge clk);
         @(negedge clk);
         check($sformatf("%s[%0d].done_p", name, i), 16'(done_p), 16'(exp_done[1][i]));
         check($sformatf("%s[%0d].perr_p", name, i), 16'(perr_p), 16'(exp_perr[1][i]));
         check($sformatf("%s[%0d].ferr_p", name, i), 16'(ferr_p), 16'(exp_ferr[1][i]));
         check($sformatf("%s[%0d].byte_p", name, i), 16'(ob_p), 16'(exp_byte[1][i]));
         check($sformatf("%s[%0d].done_n", name, i), 16'(done_n), 16'(exp_done[0][i]));
         check($sformatf("%s[%0d].perr_n", name, i), 16'(perr_n), 16'(exp_perr[0][i]));
         check($sformatf("%s[%0d].ferr_n", name, i), 16'(ferr_n), 16'(exp_ferr[0][i]));
         check($sformatf("%s[%0d].byte_n", name, i), 16'(ob_n), 16'(exp_byte[0][i]));
      end
      $display("stream %s: %0d bits, checks %0d errors %0d", name, n, checks, errors);
      stream_q.delete();
   endtask

   task automatic check_all_zero(input string name);
      check({name, ".byte_p"}, 16'(ob_p), 16'h0);
      check({name, ".done_p"}, 16'(done_p), 16'h0);
      check({name, ".perr_p"}, 16'(perr_p), 16'h0);
      check({name, ".ferr_p"}, 16'(ferr_p), 16'h0);
      check({name, ".byte_n"}, 16'(ob_n), 16'h0);
      check({name, ".done_n"}, 16'(done_n), 16'h0);
      check({name, ".perr_n"}, 16'(perr_n), 16'h0);
      check({name, ".ferr_n"}, 16'(ferr_n), 16'h0);
   endtask

   initial begin
      logic [W-1:0] w;
      int mode;
      areset = 1'b1;
      in     = 1'b1;
      #1;
      check_all_zero("reset");
      @(negedge clk);
      areset = 1'b0;
      last_byte[0] = '0;
      last_byte[1] = '0;

      // Good frame A5 then the same frame with a bad parity bit.
      repeat (3) stream_q.push_back(1'b1);
      push_frame(8'hA5, 1'b1, 1'b0, 1'b1, 3);
      push_frame(8'hA5, 1'b1, 1'b1, 1'b1, 3);
      run_stream("parity");

      // Framing error: 3C with stop 0, line low three more cycles, then idle.
      push_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0);
      repeat (3) stream_q.push_back(1'b0);
      repeat (2) stream_q.push_back(1'b1);
      run_stream("framing");

      // Back-to-back: second start bit lands in the DONE cycle.
      push_frame(8'h01, 1'b1, 1'b0, 1'b1, 0);
      push_frame(8'hFF, 1'b1, 1'b0, 1'b1, 2);
      run_stream("b2b");

      // No-parity format frame C3.
      stream_q.push_back(1'b1);
      push_frame(8'hC3, 1'b0, 1'b0, 1'b1, 2);
      run_stream("nopar");

      // Reset mid-frame, after the start bit and four data bits.
      for (int i = 0; i < 7; i++) begin
         in = (i < 2) ? 1'b1 : ((i == 2) ? 1'b0 : 1'(i & 1));
         @(posedge clk);
         @(negedge clk);
      end
      #2 areset = 1'b1;
      #1;
      check_all_zero("midreset");
      @(negedge clk);
      areset = 1'b0;
      in     = 1'b1;
      last_byte[0] = '0;
      last_byte[1] = '0;
      push_frame(8'h5A, 1'b1, 1'b0, 1'b1, 2);
      run_stream("after_reset");

      // Randomized frames with mixed faults and gaps.
      for (int f = 0; f < 40; f++) begin
         w    = W'($urandom);
         mode = $urandom_range(0, 9);
         case (mode)
            0, 1: push_frame(w, 1'b1, 1'b1, 1'b1, $urandom_range(0, 3));
            2: begin
               push_frame(w, 1'b1, 1'b0, 1'b0, 0);
               repeat ($urandom_range(0, 3)) stream_q.push_back(1'b0);
               repeat ($urandom_range(1, 3)) stream_q.push_back(1'b1);
            end
            3: push_frame(w, 1'b0, 1'b0, 1'b1, $urandom_range(0, 3));
            default: push_frame(w, 1'b1, 1'b0, 1'b1, $urandom_range(0, 3));
         endcase
      end
      run_stream("rand_frames");

      // Unstructured line noise, biased toward idle.
      for (int i = 0; i < 300; i++)
         stream_q.push_back(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
      run_stream("rand_bits");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
